// File: rtl/pad_pkg.sv
// pad_pkg: shared types and helpers for the padded-frame scheduler.
//   padState_e  : scheduler FSM states
//   CoordWidth  : width of padded x/y coordinates
//   borderOf    : border width b = (kernelSize-1)/2
//   paddedDim   : active dimension plus a border on both sides
package pad_pkg;

    localparam int unsigned CoordWidth = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } padState_e;

    function automatic int unsigned borderOf(input int unsigned kernelSize);
        return (kernelSize - 1) / 2;
    endfunction

    function automatic int unsigned paddedDim(input int unsigned active,
                                              input int unsigned kernelSize);
        return active + 2 * borderOf(kernelSize);
    endfunction

endpackage

// File: rtl/pad_coord_counter.sv
// pad_coord_counter: raster x/y counter over the zero-padded frame.
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : return to (0,0)
//   advance     : step one pixel in raster order (wraps at the padded frame end)
//   x, y        : current padded coordinate
//   lastPixel   : current coordinate is (W'-1, H'-1)
//   interior    : current coordinate lies inside the active image
module pad_coord_counter
    import pad_pkg::*;
#(
    parameter int unsigned width      = 320,
    parameter int unsigned height     = 240,
    parameter int unsigned kernelSize = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  advance,
    output logic [CoordWidth-1:0] x,
    output logic [CoordWidth-1:0] y,
    output logic                  lastPixel,
    output logic                  interior
);

    localparam int unsigned border = borderOf(kernelSize);
    localparam logic [CoordWidth-1:0] lastX = CoordWidth'(paddedDim(width, kernelSize) - 1);
    localparam logic [CoordWidth-1:0] lastY = CoordWidth'(paddedDim(height, kernelSize) - 1);
    localparam logic [CoordWidth-1:0] loX   = CoordWidth'(border);
    localparam logic [CoordWidth-1:0] hiX   = CoordWidth'(border + width);
    localparam logic [CoordWidth-1:0] loY   = CoordWidth'(border);
    localparam logic [CoordWidth-1:0] hiY   = CoordWidth'(border + height);

    logic [CoordWidth-1:0] xQ, xD, yQ, yD;

    always_comb begin
        xD = xQ;
        yD = yQ;
        if (clear) begin
            xD = '0;
            yD = '0;
        end else if (advance) begin
            if (xQ == lastX) begin
                xD = '0;
                yD = (yQ == lastY) ? '0 : yQ + 16'd1;
            end else begin
                xD = xQ + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xQ <= '0;
            yQ <= '0;
        end else begin
            xQ <= xD;
            yQ <= yD;
        end
    end

    assign x         = xQ;
    assign y         = yQ;
    assign lastPixel = (xQ == lastX) && (yQ == lastY);
    assign interior  = (xQ >= loX) && (xQ < hiX) && (yQ >= loY) && (yQ < hiY);

endmodule

// File: rtl/pad_scheduler.sv
// pad_scheduler: walks a zero-padded frame in raster order, pulling interior pixels
// from a show-ahead FIFO and inserting zero border pixels, then emits flushLen zero
// beats to drain the downstream filter and pulses oDone.
//   clk, reset            : clock, asynchronous active-high reset
//   iStart, iAbort        : frame start pulse, synchronous abort
//   iFifoEmpty, iFifoData : show-ahead FIFO status and head word
//   oFifoRdreq            : pop the head word (combinational)
//   oData, oValid, oX, oY : registered output beat and its padded coordinate
//   oBusy                 : FSM not idle
//   oDone                 : one-cycle pulse after the last flush beat
//   oErrOverlap           : sticky, iStart seen while busy
module pad_scheduler
    import pad_pkg::*;
#(
    parameter int unsigned width      = 320,
    parameter int unsigned height     = 240,
    parameter int unsigned kernelSize = 7,
    parameter int unsigned dataWidth  = 24,
    parameter int unsigned flushLen   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iStart,
    input  logic                  iAbort,
    input  logic                  iFifoEmpty,
    input  logic [dataWidth-1:0]  iFifoData,
    output logic                  oFifoRdreq,
    output logic [dataWidth-1:0]  oData,
    output logic                  oValid,
    output logic [CoordWidth-1:0] oX,
    output logic [CoordWidth-1:0] oY,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oErrOverlap
);

    localparam logic [15:0] flushLast = 16'(flushLen);

    padState_e             stateQ, stateD;
    logic [15:0]           flushCntQ, flushCntD;
    logic                  errQ, errD;
    logic                  clearCoord, advance;
    logic [CoordWidth-1:0] x, y;
    logic                  lastPixel, interior;
    logic                  rdreq;
    logic [dataWidth-1:0]  dataD;
    logic                  validD, doneD;
    logic [CoordWidth-1:0] xOutD, yOutD;

    pad_coord_counter #(
        .width     (width),
        .height    (height),
        .kernelSize(kernelSize)
    ) uCoord (
        .clk      (clk),
        .reset    (reset),
        .clear    (clearCoord),
        .advance  (advance),
        .x        (x),
        .y        (y),
        .lastPixel(lastPixel),
        .interior (interior)
    );

    always_comb begin
        stateD     = stateQ;
        flushCntD  = flushCntQ;
        errD       = errQ;
        clearCoord = 1'b0;
        advance    = 1'b0;
        rdreq      = 1'b0;
        dataD      = '0;
        validD     = 1'b0;
        doneD      = 1'b0;
        xOutD      = oX;
        yOutD      = oY;
        if (iAbort) begin
            // Abort also suppresses the pop so no FIFO word is silently dropped.
            stateD = StIdle;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (iStart) begin
                        stateD     = StRun;
                        clearCoord = 1'b1;
                        flushCntD  = '0;
                        errD       = 1'b0;
                    end
                end
                StRun: begin
                    if (iStart) errD = 1'b1;
                    // Coordinates track the decision point, so they hold through bubbles.
                    xOutD = x;
                    yOutD = y;
                    if (!interior || !iFifoEmpty) begin
                        validD  = 1'b1;
                        advance = 1'b1;
                        if (interior) begin
                            rdreq = 1'b1;
                            dataD = iFifoData;
                        end
                        if (lastPixel) stateD = StFlush;
                    end
                end
                StFlush: begin
                    if (iStart) errD = 1'b1;
                    if (flushCntQ == flushLast) begin
                        stateD = StIdle;
                        doneD  = 1'b1;
                    end else begin
                        validD    = 1'b1;
                        flushCntD = flushCntQ + 16'd1;
                    end
                end
                default: stateD = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ    <= StIdle;
            flushCntQ <= '0;
            errQ      <= 1'b0;
            oData     <= '0;
            oValid    <= 1'b0;
            oX        <= '0;
            oY        <= '0;
            oDone     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            flushCntQ <= flushCntD;
            errQ      <= errD;
            oData     <= dataD;
            oValid    <= validD;
            oX        <= xOutD;
            oY        <= yOutD;
            oDone     <= doneD;
        end
    end

    assign oFifoRdreq  = rdreq;
    assign oBusy       = (stateQ != StIdle);
    assign oErrOverlap = errQ;

endmodule

// File: doc/pad_scheduler.md
# pad_scheduler

Sequencer between the demosaic output FIFO and the 2-D convolution filter. It walks a zero-padded frame in raster order, pulls interior pixels from the show-ahead FIFO, and inserts zero boundary pixels around every row and frame edge. After the last padded pixel it drives zero-valued flush beats to drain the filter pipeline, then signals frame completion. It replaces ad-hoc skip, boundary and pipeline-enable counters with one state machine.

## Interface
- `width`, 320, active pixels per row
- `height`, 240, active rows per frame
- `kernelSize`, 7, filter kernel size (odd, ≥3); border b = (kernelSize-1)/2
- `dataWidth`, 24, pixel width ({R,G,B} 8 bits each)
- `flushLen`, 8, zero beats emitted after the last padded pixel (filter arithmetic latency)
- `clk` in 1: single clock, all logic rising-edge
- `reset` in 1: asynchronous, active-high
- `iStart` in 1: one-cycle frame start (newFrame)
- `iAbort` in 1: synchronous abort of the current frame
- `iFifoEmpty` in 1: demosaic FIFO empty
- `iFifoData` in dataWidth: FIFO head word, valid while !iFifoEmpty (show-ahead)
- `oFifoRdreq` out 1: pops the head word (combinational)
- `oData` out dataWidth: pixel to filter
- `oValid` out 1: oData beat valid
- `oX`, `oY` out 16 each: padded coordinates of the current oData
- `oBusy` out 1: state ≠ IDLE
- `oDone` out 1: one-cycle pulse, frame fully emitted and flushed
- `oErrOverlap` out 1: sticky, iStart seen while busy

## Operation
- Padded frame: W' = width+2b, H' = height+2b. Interior: b ≤ x < b+width and b ≤ y < b+height.
- States: IDLE, RUN, FLUSH.
- IDLE: on iStart → RUN with x=y=0 and flush counter cleared; oErrOverlap cleared.
- RUN, non-interior coordinate: emit zero beat with oValid=1; advance.
- RUN, interior coordinate, !iFifoEmpty: oFifoRdreq=1; emit iFifoData; advance.
- RUN, interior coordinate, iFifoEmpty: oFifoRdreq=0 and oValid=0 (bubble); coordinates hold.
- Advance: x+1; at x=W'-1, x←0 and y+1. Advancing from (W'-1, H'-1) → FLUSH.
- FLUSH: emit flushLen zero beats (oValid=1, oX/oY hold last value), then → IDLE with oDone pulsed. If flushLen=0, go straight to IDLE with oDone.
- oFifoRdreq = (state==RUN) & interior & !iFifoEmpty. The FIFO is never read outside RUN.
- iStart while RUN/FLUSH: ignored and sets oErrOverlap.
- iAbort in any state → IDLE next cycle; no oDone; oValid=0 that cycle. iAbort wins over iStart in the same cycle.
- Exactly W'·H' + flushLen valid beats per completed frame, of which width·height carry FIFO data.

## Timing
- Reset values: oData=0, oValid=0, oX=0, oY=0, oBusy=0, oDone=0, oErrOverlap=0, state IDLE.
- oData, oValid, oX, oY, oDone are registered: 1-cycle latency from the pop/decision cycle.
- First beat (0,0) appears 2 cycles after the iStart cycle (1 cycle to enter RUN, 1 output register).
- With FIFO never empty, the frame streams at 1 beat/cycle: RUN lasts exactly W'·H' cycles.
- oDone is asserted in the cycle after the last flush beat appears on the output.
- oBusy reflects state combinationally (high the cycle after iStart).

## Structure
- Shared package `pad_pkg`: state enum {IDLE, RUN, FLUSH}; functions for b, W', H'; coordinate width constant (16).
- Sub-module `pad_coord_counter`: x/y raster counter with advance enable, clear, last-pixel flag and interior flag. The FSM and output register stay in the top.

## Test plan
- width=8, height=4, kernelSize=3, flushLen=4, FIFO preloaded with 32 words 1..32 → 60 RUN beats: row 0 and row 5 all zero; row 1 = 0,1..8,0; then 4 zero flush beats; oDone on cycle 66 after iStart; 32 pops.
- Same config, FIFO empty for 5 cycles on the pop at (1,2) → 5 oValid=0 bubbles, oX/oY hold at (1,2), no beat lost or duplicated, total valid beats still 64.
- iStart pulsed at beat 20 of RUN → ignored, oErrOverlap=1 until the next IDLE iStart, frame output unchanged.
- iAbort at (4,3) → IDLE next cycle, no oDone; a new iStart restarts at (0,0) with FIFO reads resuming at the current head.
- reset asserted mid-FLUSH → all outputs 0 immediately; after release oBusy=0 and no oDone.
- kernelSize=7, width=320, height=240 → 326·246 = 80196 RUN beats, 76800 pops, border zeros 3 pixels wide on every edge.
